// File: rtl/timer_irq_ctrl.sv
// Memory-mapped timer with a prescaled up-counter, auto-reload on overflow,
// and a three-state interrupt handshake (IDLE -> PEND -> SERV) towards the CPU.
// TH holds the reload value, TL is the live counter, TCON = {ST, IE, EN}.
module timer_irq_ctrl #(
   parameter logic [31:0] BASE     = 32'h4000_0000,
   parameter int          PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   input  logic        irq_ack,
   input  logic        eret
);

   localparam logic [31:0] TH_ADDR   = BASE;
   localparam logic [31:0] TL_ADDR   = BASE + 32'd4;
   localparam logic [31:0] TCON_ADDR = BASE + 32'd8;
   localparam logic [15:0] PRE_MAX   = 16'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, PEND, SERV} irqState_t;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        st_q, st_d;
   logic [15:0] pre_q, pre_d;
   irqState_t   state_q;
   logic        irq_q;

   logic [31:0] aligned;
   logic        selTh, selTl, selTcon;
   logic        tick, overflow, armed;

   // Byte-lane bits are masked off so any address within a word selects it.
   assign aligned = addr & 32'hFFFF_FFFC;
   assign selTh   = (aligned == TH_ADDR);
   assign selTl   = (aligned == TL_ADDR);
   assign selTcon = (aligned == TCON_ADDR);

   assign tick     = en_q && (pre_q == PRE_MAX);
   // A TL write on the same edge discards the tick, so it cannot overflow either.
   assign overflow = tick && (tl_q == 32'hFFFF_FFFF) && !(wr && selTl);
   assign armed    = st_q && ie_q;
   assign irq      = irq_q;

   // Combinational read mux; unmatched addresses and idle cycles return zero.
   always_comb begin
      rdata = 32'd0;
      if (rd) begin
         if (selTh)        rdata = th_q;
         else if (selTl)   rdata = tl_q;
         else if (selTcon) rdata = {29'd0, st_q, ie_q, en_q};
      end
   end

   // Next-state for the prescaler and the register file, including the
   // write-versus-tick priorities and the sticky ST set on overflow.
   always_comb begin
      pre_d = 16'd0;
      if (en_q) pre_d = tick ? 16'd0 : pre_q + 16'd1;

      th_d = th_q;
      if (wr && selTh) th_d = wdata;

      tl_d = tl_q;
      if (wr && selTl)  tl_d = wdata;
      else if (tick)    tl_d = (tl_q == 32'hFFFF_FFFF) ? th_q : tl_q + 32'd1;

      en_d = en_q;
      ie_d = ie_q;
      st_d = st_q || (overflow && ie_q);
      if (wr && selTcon) begin
         en_d = wdata[0];
         ie_d = wdata[1];
         st_d = wdata[2] || (overflow && ie_q);
      end
   end

   // Register file and prescaler state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q  <= 32'd0;
         tl_q  <= 32'd0;
         en_q  <= 1'b0;
         ie_q  <= 1'b0;
         st_q  <= 1'b0;
         pre_q <= 16'd0;
      end else begin
         th_q  <= th_d;
         tl_q  <= tl_d;
         en_q  <= en_d;
         ie_q  <= ie_d;
         st_q  <= st_d;
         pre_q <= pre_d;
      end
   end

   // Interrupt handshake FSM; irq is registered and high only in PEND,
   // and an acknowledge beats a simultaneous disarm.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (armed) begin
                  state_q <= PEND;
                  irq_q   <= 1'b1;
               end
            end
            PEND: begin
               if (irq_ack) begin
                  state_q <= SERV;
                  irq_q   <= 1'b0;
               end else if (!armed) begin
                  state_q <= IDLE;
                  irq_q   <= 1'b0;
               end
            end
            SERV: begin
               irq_q <= 1'b0;
               if (eret) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench for timer_irq_ctrl: two instances (prescale 1 and 4) share
// the bus; expected values are queued when stimulus is issued and compared
// when the corresponding output is sampled.
module tb_timer_irq_ctrl;

   localparam logic [31:0] TH_A   = 32'h4000_0000;
   localparam logic [31:0] TL_A   = 32'h4000_0004;
   localparam logic [31:0] TCON_A = 32'h4000_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr, irqAck, eret;
   logic [31:0] addr, wdata;
   logic [31:0] rdata1, rdata4;
   logic        irq1, irq4;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } expT;
   expT sbQ[$];

   timer_irq_ctrl #(.BASE(32'h4000_0000), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .irq(irq1), .irq_ack(irqAck), .eret(eret)
   );

   timer_irq_ctrl #(.BASE(32'h4000_0000), .PRESCALE(4)) dut4 (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata4), .irq(irq4), .irq_ack(irqAck), .eret(eret)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pushExpect(input string tag, input logic [31:0] exp);
      expT e;
      e.tag = tag;
      e.exp = exp;
      sbQ.push_back(e);
   endtask

   // Pops the oldest expectation and compares it with the sampled output.
   task automatic popCompare(input logic [31:0] obs);
      expT e;
      if (sbQ.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkOutput(e.tag, obs, e.exp);
      end
   endtask

   // Advance n rising edges, returning 1 time unit after the last one.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Single-cycle bus write; the register updates on the edge consumed here.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
      wr    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      wr = 1'b0;
   endtask

   // Combinational read between edges from the selected instance.
   task automatic readReg(input string tag, input logic [31:0] a, input logic [31:0] exp, input bit sel4);
      pushExpect(tag, exp);
      rd   = 1'b1;
      addr = a;
      #1;
      popCompare(sel4 ? rdata4 : rdata1);
      rd = 1'b0;
   endtask

   task automatic checkIrq(input string tag, input logic exp, input bit sel4);
      pushExpect(tag, {31'd0, exp});
      popCompare({31'd0, sel4 ? irq4 : irq1});
   endtask

   initial begin
      reset  = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      irqAck = 1'b0;
      eret   = 1'b0;
      addr   = 32'd0;
      wdata  = 32'd0;

      // Reset state is visible while reset is still held.
      #2;
      readReg("rst_th", TH_A, 32'd0, 0);
      readReg("rst_tl", TL_A, 32'd0, 0);
      readReg("rst_tcon", TCON_A, 32'd0, 0);
      checkIrq("rst_irq", 1'b0, 0);
      #4 reset = 1'b1;
      step(1);
      readReg("post_rst_tl", TL_A, 32'd0, 0);

      // Overflow reload and irq raise with prescale 1.
      $display("[TB] overflow and reload");
      applyStimulus(TH_A, 32'hFFFF_FFF0);
      applyStimulus(TL_A, 32'hFFFF_FFFE);
      applyStimulus(TCON_A, 32'h3);
      step(1);
      readReg("tl_ff", TL_A, 32'hFFFF_FFFF, 0);
      checkIrq("irq_before_ovf", 1'b0, 0);
      step(1);
      readReg("tl_reload", TL_A, 32'hFFFF_FFF0, 0);
      readReg("tcon_st_set", TCON_A, 32'h7, 0);
      checkIrq("irq_not_yet", 1'b0, 0);
      step(1);
      checkIrq("irq_raised", 1'b1, 0);
      readReg("tl_after_reload", TL_A, 32'hFFFF_FFF1, 0);

      // Acknowledge, second overflow during service, then return.
      $display("[TB] acknowledge and return");
      irqAck = 1'b1;
      step(1);
      irqAck = 1'b0;
      checkIrq("irq_after_ack", 1'b0, 0);
      readReg("st_kept_after_ack", TCON_A, 32'h7, 0);
      for (int i = 0; i < 20; i++) begin
         step(1);
         checkIrq("irq_in_serv", 1'b0, 0);
      end
      eret = 1'b1;
      step(1);
      eret = 1'b0;
      checkIrq("irq_eret_edge1", 1'b0, 0);
      step(1);
      checkIrq("irq_eret_edge2", 1'b1, 0);

      // Clearing ST in the overflow cycle must not lose the event.
      $display("[TB] ST clear race");
      applyStimulus(TCON_A, 32'h0);
      readReg("tcon_cleared", TCON_A, 32'h0, 0);
      applyStimulus(TL_A, 32'hFFFF_FFFD);
      applyStimulus(TCON_A, 32'h3);
      step(2);
      readReg("tl_pre_ovf", TL_A, 32'hFFFF_FFFF, 0);
      applyStimulus(TCON_A, 32'h3);
      readReg("tcon_race", TCON_A, 32'h7, 0);
      readReg("tl_race_reload", TL_A, 32'hFFFF_FFF0, 0);

      // A TL write beats a simultaneous tick.
      applyStimulus(TL_A, 32'h5);
      readReg("tl_write_prio", TL_A, 32'h5, 0);
      step(1);
      readReg("tl_after_prio", TL_A, 32'h6, 0);

      // Prescale 4: one increment every four edges, frozen when disabled.
      $display("[TB] prescaler");
      applyStimulus(TCON_A, 32'h0);
      applyStimulus(TL_A, 32'h0);
      applyStimulus(TCON_A, 32'h1);
      step(3);
      readReg("pre4_edge3", TL_A, 32'h0, 1);
      step(1);
      readReg("pre4_edge4", TL_A, 32'h1, 1);
      step(3);
      readReg("pre4_edge7", TL_A, 32'h1, 1);
      step(1);
      readReg("pre4_edge8", TL_A, 32'h2, 1);
      applyStimulus(TCON_A, 32'h0);
      step(10);
      readReg("pre4_frozen", TL_A, 32'h2, 1);

      // Address decode boundaries.
      $display("[TB] address decode");
      readReg("rd_unmapped", 32'h4000_000C, 32'h0, 1);
      readReg("rd_th_low_bits", 32'h4000_0003, 32'hFFFF_FFF0, 1);
      applyStimulus(32'h4000_000C, 32'hFFFF_FFFF);
      readReg("unmapped_wr_th", TH_A, 32'hFFFF_FFF0, 1);
      readReg("unmapped_wr_tl", TL_A, 32'h2, 1);
      readReg("unmapped_wr_tcon", TCON_A, 32'h0, 1);
      applyStimulus(32'h4000_0007, 32'h0000_ABCD);
      readReg("wr_tl_low_bits", TL_A, 32'h0000_ABCD, 1);
      applyStimulus(TCON_A, 32'hFFFF_FFF8);
      readReg("tcon_upper_ignored", TCON_A, 32'h0, 1);

      // Reset while in service abandons everything.
      $display("[TB] reset during service");
      applyStimulus(TH_A, 32'h1230);
      applyStimulus(TL_A, 32'hFFFF_FFFF);
      applyStimulus(TCON_A, 32'h3);
      step(1);
      readReg("serv_reload", TL_A, 32'h1230, 0);
      step(1);
      checkIrq("serv_pend", 1'b1, 0);
      irqAck = 1'b1;
      step(1);
      irqAck = 1'b0;
      applyStimulus(TCON_A, 32'h6);
      applyStimulus(TL_A, 32'h1234);
      readReg("serv_tl", TL_A, 32'h1234, 0);
      readReg("serv_tcon", TCON_A, 32'h6, 0);
      checkIrq("serv_irq_low", 1'b0, 0);
      reset = 1'b0;
      #1;
      readReg("mid_rst_th", TH_A, 32'h0, 0);
      readReg("mid_rst_tl", TL_A, 32'h0, 0);
      readReg("mid_rst_tcon", TCON_A, 32'h0, 0);
      checkIrq("mid_rst_irq", 1'b0, 0);
      reset = 1'b1;
      step(1);
      eret = 1'b1;
      step(1);
      eret = 1'b0;
      step(2);
      checkIrq("post_rst_eret_irq", 1'b0, 0);
      readReg("post_rst_tcon", TCON_A, 32'h0, 0);
      readReg("post_rst_tl2", TL_A, 32'h0, 0);

      if (sbQ.size() != 0) checkOutput("scoreboard_leftover", sbQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
